sys_arr_feeder: RTL and testbench



---
 rtl/sys_arr_feeder.sv | 80 ++++++++
 tb/tb_sys_arr_feeder.sv | 96 +++++++++
 2 files changed

// File: rtl/sys_arr_feeder.sv
// sys_arr_feeder: skews column vectors onto systolic-array rows; SYS_ARR_FEEDER_STALL_CNT_EN adds stall_cnt.
module sys_arr_feeder #(
  parameter int width_height = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [8*width_height-1:0] in_data,
  input  logic                      in_last,
  output logic [8*width_height-1:0] datain,
  output logic                      active,
  output logic                      busy,
  output logic                      done
`ifdef SYS_ARR_FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]               stall_cnt
`endif
);
  localparam int CW = $clog2(width_height) + 1;
  localparam logic [CW-1:0] DRAIN_LD = (width_height > 1) ? CW'(width_height - 2) : '0;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          done_q, active_q;
  logic          acc;
  assign in_ready = (state_q != DRAIN) && !reset;
  assign acc      = in_valid && in_ready;
  assign busy     = state_q != IDLE;
  assign done     = done_q;
  assign active   = active_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      active_q <= acc;
      done_q   <= 1'b0;
      case (state_q)
        IDLE, STREAM:
          if (acc && in_last) begin
            // a single-row array has nothing left in flight, so it finishes at once
            if (width_height == 1) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              state_q <= DRAIN;
              cnt_q   <= DRAIN_LD;
            end
          end else if (acc) state_q <= STREAM;
        default:
          if (cnt_q == '0) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else cnt_q <= cnt_q - 1'b1;
      endcase
    end
`ifdef SYS_ARR_FEEDER_STALL_CNT_EN
  logic [15:0] stall_q;
  assign stall_cnt = stall_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) stall_q <= '0;
    else if (state_q == IDLE && acc) stall_q <= '0;
    else if (state_q == STREAM && !in_valid && stall_q != '1) stall_q <= stall_q + 16'd1;
`endif
  // row g sits behind g+1 registers; bubbles push zeros
  for (genvar g = 0; g < width_height; g++) begin : g_lane
    logic [7:0] sr_q [0:g];
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        for (int k = 0; k <= g; k++) sr_q[k] <= '0;
      end else begin
        sr_q[0] <= acc ? in_data[8*g+:8] : 8'h00;
        for (int k = 1; k <= g; k++) sr_q[k] <= sr_q[k-1];
      end
    assign datain[8*g+:8] = sr_q[g];
  end
endmodule

// File: tb/tb_sys_arr_feeder.sv
// tb_sys_arr_feeder: drives widths 1, 2 and 4 from one stream and checks each against a timeline model.
module tb_sys_arr_feeder;
  logic        clk = 1'b0, rst = 1'b1, vld = 1'b0, lst = 1'b0;
  logic [31:0] dat = '0;
  int          n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  for (genvar g = 0; g < 3; g++) begin : g_w
    localparam int W = 1 << g;
    logic [8*W-1:0] dout;
    logic           rdy, act, bsy, dn;
`ifdef SYS_ARR_FEEDER_STALL_CNT_EN
    logic [15:0]    stl;
`endif
    sys_arr_feeder #(.width_height(W)) dut (
      .clk(clk), .reset(rst), .in_valid(vld), .in_ready(rdy), .in_data(dat[8*W-1:0]),
      .in_last(lst), .datain(dout), .active(act), .busy(bsy), .done(dn)
`ifdef SYS_ARR_FEEDER_STALL_CNT_EN
      , .stall_cnt(stl)
`endif
    );
    // history of vectors entering the array: past[k] entered k edges before the newest one
    initial begin : model
      logic [31:0] past [0:4];
      logic [31:0] ex;
      int          n, e, c, stall;
      bit          hl, ip, a, idle, win;
      n = 0; e = 0; stall = 0; hl = 0; ip = 0; a = 0;
      for (int k = 0; k < 5; k++) past[k] = '0;
      forever begin
        @(posedge clk);
        c = n + 1;
        win = hl && n >= e + 1 && n <= e + W - 1;
        if (rst) begin
          for (int k = 0; k < 5; k++) past[k] = '0;
          hl = 0; ip = 0; a = 0; stall = 0;
        end else begin
          idle = !ip && !win;
          a = vld && !win;
          if (ip && !vld && stall < 65535) stall++;
          if (idle && a) stall = 0;
          for (int k = 4; k > 0; k--) past[k] = past[k-1];
          past[0] = a ? dat : '0;
          if (a && lst) begin
            e = n; hl = 1; ip = 0;
          end else if (a) ip = 1;
        end
        #2;
        ex = '0;
        for (int i = 0; i < W; i++) ex[8*i+:8] = past[i][8*i+:8];
        check($sformatf("w%0d datain", W), 32'(dout), ex);
        check($sformatf("w%0d active", W), 32'(act), 32'(a));
        check($sformatf("w%0d done", W), 32'(dn), 32'(!rst && hl && c == e + W));
        check($sformatf("w%0d busy", W), 32'(bsy), 32'(!rst && (ip || (hl && c >= e + 1 && c <= e + W - 1))));
        check($sformatf("w%0d in_ready", W), 32'(rdy), 32'(!rst && !(hl && c >= e + 1 && c <= e + W - 1)));
`ifdef SYS_ARR_FEEDER_STALL_CNT_EN
        check($sformatf("w%0d stall_cnt", W), 32'(stl), 32'(stall));
`endif
        n++;
      end
    end
  end
  task automatic step(input logic r, input logic v, input logic l, input logic [31:0] d);
    @(negedge clk);
    rst = r; vld = v; lst = l; dat = d;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step(0, 1, 0, 32'h0000_0201); step(0, 1, 1, 32'h0000_0403);
    repeat (5) step(0, 0, 0, 0);
    step(0, 1, 1, 32'h4433_2211);
    repeat (6) step(0, 0, 0, 0);
    step(0, 1, 0, 32'h0a0b_0c0d);
    repeat (3) step(0, 0, 0, 0);
    step(0, 1, 1, 32'h0102_0304);
    repeat (6) step(0, 0, 0, 0);
    step(0, 1, 1, 32'h5566_7788); step(1, 0, 0, 0); step(0, 0, 0, 0);
    step(0, 1, 1, 32'h7f7f_7f7f);
    repeat (5) step(0, 0, 0, 0);
    repeat (8) step(0, 1, 1, $urandom);
    repeat (5) step(0, 0, 0, 0);
    repeat (3000) step($urandom_range(0, 149) == 0, $urandom_range(0, 9) < 6,
                       $urandom_range(0, 3) == 0, $urandom);
    repeat (8) step(0, 0, 0, 0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
